// File: rtl/enemy_pkg.sv
// ============================================================================
// Module      : enemy_pkg
// Description : Shared enemy types, facing codes, screen bounds and the
//               clamped position-update helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_pkg;

    // Life cycle of one enemy
    typedef enum logic [1:0] {
        S_SPAWN = 2'd0,
        S_CHASE = 2'd1,
        S_HIT   = 2'd2,
        S_DEAD  = 2'd3
    } enemy_state_t;

    // Facing codes consumed by the walk animation
    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Playfield bounds shared with the player and bullet blocks (min is 0)
    localparam logic [8:0] SCREEN_X_MAX = 9'd303;
    localparam logic [8:0] SCREEN_Y_MAX = 9'd223;

    // pos + signed motion, saturated to [0, max]; widened so nothing wraps
    function automatic logic [8:0] clamp_pos(
        input logic [8:0] pos,
        input logic [8:0] motion,
        input logic [8:0] max
    );
        logic signed [10:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{2{motion[8]}}, motion});
        if (sum < 11'sd0) begin
            return 9'd0;
        end else if (sum > $signed({2'b00, max})) begin
            return max;
        end else begin
            return sum[8:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_axis_step.sv
// ============================================================================
// Module      : enemy_axis_step
// Description : One-axis chase step. Produces a signed move of at most STEP
//               pixels toward the target, plus |target - pos| so the top
//               level can decide which axis sets the facing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_axis_step #(
    parameter logic [8:0] STEP = 9'd1
) (
    input  logic [8:0] pos,
    input  logic [8:0] target,
    output logic [8:0] motion,
    output logic [8:0] abs_d
);

    logic [9:0] w_d;
    logic [8:0] w_mag;

    // Signed distance, its magnitude, and the step limited so it never overshoots
    always_comb begin
        w_d   = {1'b0, target} - {1'b0, pos};
        abs_d = w_d[9] ? (~w_d[8:0] + 9'd1) : w_d[8:0];
        w_mag = (abs_d < STEP) ? abs_d : STEP;
        motion = w_d[9] ? (9'd0 - w_mag) : w_mag;
    end

endmodule

`default_nettype wire

// File: rtl/enemy_chase.sv
// ============================================================================
// Module      : enemy_chase
// Description : Per-enemy chase stage. Each frame moves one step toward the
//               player, tracks facing and hit points, and sequences the
//               spawn / chase / hit / dead life cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_chase
    import enemy_pkg::*;
#(
    parameter logic [8:0] SPAWN_X      = 9'd16,
    parameter logic [8:0] SPAWN_Y      = 9'd16,
    parameter logic [8:0] STEP         = 9'd1,
    parameter logic [8:0] X_MAX        = SCREEN_X_MAX,
    parameter logic [8:0] Y_MAX        = SCREEN_Y_MAX,
    parameter logic [1:0] HP_INIT      = 2'd3,
    parameter logic [7:0] SPAWN_FRAMES = 8'd30,
    parameter logic [7:0] HIT_FRAMES   = 8'd8,
    parameter logic [7:0] DEAD_FRAMES  = 8'd60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic       Hit,
    output logic [8:0] Obj_X_Pos,
    output logic [8:0] Obj_Y_Pos,
    output logic [8:0] Obj_X_Motion,
    output logic [8:0] Obj_Y_Motion,
    output logic [1:0] Obj_Dir,
    output logic       Obj_Alive,
    output logic [1:0] Obj_Hp
);

    enemy_state_t r_state, w_state;
    logic [7:0]   r_cnt,   w_cnt;
    logic [8:0]   r_x,     w_x;
    logic [8:0]   r_y,     w_y;
    logic [1:0]   r_dir,   w_dir;
    logic [1:0]   r_hp,    w_hp;

    logic [8:0]   w_step_x, w_step_y;
    logic [8:0]   w_abs_x,  w_abs_y;
    logic [8:0]   w_x_motion, w_y_motion;

    enemy_axis_step #(.STEP(STEP)) u_step_x (
        .pos    (r_x),
        .target (Player_X),
        .motion (w_step_x),
        .abs_d  (w_abs_x)
    );

    enemy_axis_step #(.STEP(STEP)) u_step_y (
        .pos    (r_y),
        .target (Player_Y),
        .motion (w_step_y),
        .abs_d  (w_abs_y)
    );

    // State register: reset wins over everything, including Enable
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state <= S_SPAWN;
            r_cnt   <= 8'd0;
            r_x     <= SPAWN_X;
            r_y     <= SPAWN_Y;
            r_dir   <= DIR_DOWN;
            r_hp    <= HP_INIT;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_x     <= w_x;
            r_y     <= w_y;
            r_dir   <= w_dir;
            r_hp    <= w_hp;
        end
    end

    // Next-state, motion and position/facing/HP update; everything holds when disabled
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_x        = r_x;
        w_y        = r_y;
        w_dir      = r_dir;
        w_hp       = r_hp;
        w_x_motion = 9'd0;
        w_y_motion = 9'd0;

        if (Enable && (r_state == S_CHASE)) begin
            w_x_motion = w_step_x;
            w_y_motion = w_step_y;
        end

        if (Enable) begin
            case (r_state)
                S_SPAWN: begin
                    if (r_cnt == SPAWN_FRAMES - 8'd1) begin
                        w_state = S_CHASE;
                        w_cnt   = 8'd0;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
                S_CHASE: begin
                    if (Hit) begin
                        // Accepted hit: no move on this edge
                        w_cnt = 8'd0;
                        if (r_hp > 2'd1) begin
                            w_hp    = r_hp - 2'd1;
                            w_state = S_HIT;
                        end else begin
                            w_hp    = 2'd0;
                            w_state = S_DEAD;
                        end
                    end else begin
                        w_x = clamp_pos(r_x, w_x_motion, X_MAX);
                        w_y = clamp_pos(r_y, w_y_motion, Y_MAX);
                        // Dominant axis sets facing; X wins ties
                        if ((w_x_motion != 9'd0) || (w_y_motion != 9'd0)) begin
                            if (w_abs_x >= w_abs_y) begin
                                w_dir = w_x_motion[8] ? DIR_LEFT : DIR_RIGHT;
                            end else begin
                                w_dir = w_y_motion[8] ? DIR_UP : DIR_DOWN;
                            end
                        end
                    end
                end
                S_HIT: begin
                    if (r_cnt == HIT_FRAMES - 8'd1) begin
                        w_state = S_CHASE;
                        w_cnt   = 8'd0;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
                S_DEAD: begin
                    if (r_cnt == DEAD_FRAMES - 8'd1) begin
                        w_state = S_SPAWN;
                        w_cnt   = 8'd0;
                        w_x     = SPAWN_X;
                        w_y     = SPAWN_Y;
                        w_hp    = HP_INIT;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state = S_SPAWN;
                    w_cnt   = 8'd0;
                end
            endcase
        end
    end

    assign Obj_X_Pos    = r_x;
    assign Obj_Y_Pos    = r_y;
    assign Obj_X_Motion = w_x_motion;
    assign Obj_Y_Motion = w_y_motion;
    assign Obj_Dir      = r_dir;
    assign Obj_Hp       = r_hp;
    assign Obj_Alive    = (r_state == S_CHASE) || (r_state == S_HIT);

endmodule

`default_nettype wire

// File: tb/tb_enemy_chase.sv
// ============================================================================
// Module      : tb_enemy_chase
// Description : Self-checking bench for enemy_chase. A behavioural model
//               predicts every frame's outputs into a scoreboard queue, and a
//               table of segments carries hand-derived end-of-segment values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_chase;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default STEP=1)
    logic       rst, en, hit;
    logic [8:0] px, py;
    logic [8:0] ox, oy, omx, omy;
    logic [1:0] odir, ohp;
    logic       oalive;

    // Second DUT with STEP=4 for the no-overshoot case
    logic       rst4, en4, hit4;
    logic [8:0] p4x, p4y;
    logic [8:0] x4, y4, xm4, ym4;
    logic [1:0] dir4, hp4;
    logic       alive4;

    enemy_chase dut (
        .frame_clk(clk), .Reset(rst), .Enable(en),
        .Player_X(px), .Player_Y(py), .Hit(hit),
        .Obj_X_Pos(ox), .Obj_Y_Pos(oy),
        .Obj_X_Motion(omx), .Obj_Y_Motion(omy),
        .Obj_Dir(odir), .Obj_Alive(oalive), .Obj_Hp(ohp)
    );

    enemy_chase #(.STEP(9'd4)) dut4 (
        .frame_clk(clk), .Reset(rst4), .Enable(en4),
        .Player_X(p4x), .Player_Y(p4y), .Hit(hit4),
        .Obj_X_Pos(x4), .Obj_Y_Pos(y4),
        .Obj_X_Motion(xm4), .Obj_Y_Motion(ym4),
        .Obj_Dir(dir4), .Obj_Alive(alive4), .Obj_Hp(hp4)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // state: 0 spawn, 1 chase, 2 hit, 3 dead
    int m_state = 0, m_cnt = 0, m_x = 16, m_y = 16, m_dir = 0, m_hp = 3;

    typedef struct packed {
        logic [8:0] x, y, mx, my;
        logic [1:0] dir;
        logic       alive;
        logic [1:0] hp;
    } obs_t;

    obs_t sb[$];

    function automatic int mstep(int p, int t, int s);
        int d;
        d = t - p;
        if (d == 0) return 0;
        if (d > 0) return (d < s) ? d : s;
        return (-d < s) ? d : -s;
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic obs_t expect_now(logic e, int tx, int ty);
        obs_t o;
        int   mx, my;
        mx = 0; my = 0;
        if (e && m_state == 1) begin
            mx = mstep(m_x, tx, 1);
            my = mstep(m_y, ty, 1);
        end
        o.x     = 9'(m_x);
        o.y     = 9'(m_y);
        o.mx    = 9'(mx);
        o.my    = 9'(my);
        o.dir   = 2'(m_dir);
        o.alive = (m_state == 1) || (m_state == 2);
        o.hp    = 2'(m_hp);
        return o;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic h, input int tx, input int ty);
        int mx, my, ax, ay;
        if (r) begin
            m_state = 0; m_cnt = 0; m_x = 16; m_y = 16; m_dir = 0; m_hp = 3;
        end else if (e) begin
            case (m_state)
                0: if (m_cnt == 29) begin m_state = 1; m_cnt = 0; end else m_cnt++;
                1: begin
                    if (h) begin
                        m_cnt = 0;
                        if (m_hp > 1) begin m_hp--; m_state = 2; end
                        else begin m_hp = 0; m_state = 3; end
                    end else begin
                        mx = mstep(m_x, tx, 1);
                        my = mstep(m_y, ty, 1);
                        ax = iabs(tx - m_x);
                        ay = iabs(ty - m_y);
                        if (mx != 0 || my != 0) begin
                            if (ax >= ay) m_dir = (mx < 0) ? 2 : 3;
                            else          m_dir = (my < 0) ? 1 : 0;
                        end
                        m_x = clampi(m_x + mx, 303);
                        m_y = clampi(m_y + my, 223);
                    end
                end
                2: if (m_cnt == 7) begin m_state = 1; m_cnt = 0; end else m_cnt++;
                default: begin
                    if (m_cnt == 59) begin
                        m_state = 0; m_cnt = 0; m_x = 16; m_y = 16; m_hp = 3;
                    end else m_cnt++;
                end
            endcase
        end
    endtask

    // One frame: drive at negedge, predict, compare, then advance the model at the edge
    task automatic step(input logic r, input logic e, input logic h, input int tx, input int ty);
        obs_t exp_o, act_o;
        @(negedge clk);
        rst = r; en = e; hit = h; px = 9'(tx); py = 9'(ty);
        #1;
        sb.push_back(expect_now(e, tx, ty));
        exp_o = sb.pop_front();
        act_o = '{x: ox, y: oy, mx: omx, my: omy, dir: odir, alive: oalive, hp: ohp};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL frame t=%0t: got x=%0d y=%0d mx=%h my=%h dir=%0d alive=%0b hp=%0d, want x=%0d y=%0d mx=%h my=%h dir=%0d alive=%0b hp=%0d",
                     $time, act_o.x, act_o.y, act_o.mx, act_o.my, act_o.dir, act_o.alive, act_o.hp,
                     exp_o.x, exp_o.y, exp_o.mx, exp_o.my, exp_o.dir, exp_o.alive, exp_o.hp);
        end
        @(posedge clk);
        model_edge(r, e, h, tx, ty);
    endtask

    task automatic check4(input string name, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // ---------------- segment table ----------------
    typedef struct {
        logic rst, en, hit;
        int   px, py, n;
        int   ex, ey, ehp, ealive, edir;
    } seg_t;

    seg_t segs[31];

    initial begin
        rst = 1'b1; en = 1'b1; hit = 1'b0; px = 9'd100; py = 9'd16;
        rst4 = 1'b1; en4 = 1'b1; hit4 = 1'b0; p4x = 9'd98; p4y = 9'd16;

        //           rst en hit px   py  n    ex   ey  hp alive dir
        segs[0]  = '{1, 1, 0, 100, 16,   2,  16,  16, 3, 0, 0};  // reset values
        segs[1]  = '{0, 1, 0, 100, 16,  30,  16,  16, 3, 1, 0};  // 30 spawn frames
        segs[2]  = '{0, 1, 0, 100, 16,  84, 100,  16, 3, 1, 3};  // walk right to 100
        segs[3]  = '{0, 1, 0, 100, 16,   5, 100,  16, 3, 1, 3};  // on target, stays
        segs[4]  = '{0, 1, 0, 310,  0,  10, 110,   6, 3, 1, 3};
        segs[5]  = '{0, 1, 1, 310,  0,   1, 110,   6, 2, 1, 3};  // accepted hit
        segs[6]  = '{0, 1, 1, 310,  0,   3, 110,   6, 2, 1, 3};  // hits ignored in S_HIT
        segs[7]  = '{0, 1, 0, 310,  0,   2, 110,   6, 2, 1, 3};
        segs[8]  = '{0, 0, 0, 310,  0,   5, 110,   6, 2, 1, 3};  // freeze holds counter
        segs[9]  = '{0, 1, 0, 310,  0,   2, 110,   6, 2, 1, 3};  // 7th hit frame
        segs[10] = '{0, 1, 0, 310,  0,   1, 110,   6, 2, 1, 3};  // back to chase
        segs[11] = '{0, 1, 0, 310,  0,  50, 160,   0, 2, 1, 3};  // Y reaches 0, holds
        segs[12] = '{0, 0, 0, 310,  0,   4, 160,   0, 2, 1, 3};  // disabled
        segs[13] = '{0, 0, 1, 310,  0,   1, 160,   0, 2, 1, 3};  // hit dropped
        segs[14] = '{0, 0, 0, 310,  0,   5, 160,   0, 2, 1, 3};
        segs[15] = '{0, 1, 0, 310,  0, 150, 303,   0, 2, 1, 3};  // saturates at X_MAX
        segs[16] = '{0, 1, 1, 310,  0,   1, 303,   0, 1, 1, 3};
        segs[17] = '{0, 1, 0, 310,  0,   8, 303,   0, 1, 1, 3};
        segs[18] = '{0, 1, 1, 310,  0,   1, 303,   0, 0, 0, 3};  // lethal hit
        segs[19] = '{0, 1, 0, 310,  0,  59, 303,   0, 0, 0, 3};
        segs[20] = '{0, 1, 0, 310,  0,   1,  16,  16, 3, 0, 3};  // respawn
        segs[21] = '{0, 1, 0, 310,  0,  30,  16,  16, 3, 1, 3};
        segs[22] = '{0, 1, 0, 310,  0,   3,  19,  13, 3, 1, 3};
        segs[23] = '{0, 1, 0,  19,  5,   3,  19,  10, 3, 1, 1};  // up
        segs[24] = '{0, 1, 0,   0, 10,   2,  17,  10, 3, 1, 2};  // left
        segs[25] = '{0, 1, 0,  17, 40,   2,  17,  12, 3, 1, 0};  // down
        segs[26] = '{0, 1, 0,  20, 15,   4,  20,  15, 3, 1, 3};  // diagonal tie -> X
        segs[27] = '{0, 1, 1,  20, 15,   1,  20,  15, 2, 1, 3};
        segs[28] = '{0, 1, 0,  20, 15,   2,  20,  15, 2, 1, 3};
        segs[29] = '{1, 1, 0,  20, 15,   1,  16,  16, 3, 0, 0};  // reset inside S_HIT
        segs[30] = '{0, 1, 0,  20, 15,   5,  16,  16, 3, 0, 0};

        // STEP=4 instance: approach 98 then ask for 100 (only 2 px away)
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        check4("step4_reach98", x4, 9'd98);
        @(negedge clk);
        p4x = 9'd100;
        #1;
        check4("step4_motion_plus2", xm4, 9'd2);
        @(posedge clk);
        #1;
        check4("step4_pos100", x4, 9'd100);
        check4("step4_motion_zero", xm4, 9'd0);
        @(posedge clk);
        #1;
        check4("step4_no_overshoot", x4, 9'd100);
        check4("step4_y_hold", y4, 9'd16);
        check4("step4_ymotion", ym4, 9'd0);
        check4("step4_dir", {7'd0, dir4}, 9'd3);
        check4("step4_alive_hp", {6'd0, alive4, hp4}, 9'd7);

        // Main instance: table of segments, model-checked every frame
        for (int s = 0; s < 31; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                step(segs[s].rst, segs[s].en, segs[s].hit, segs[s].px, segs[s].py);
            end
            #1;
            checks++;
            if ((ox !== 9'(segs[s].ex)) || (oy !== 9'(segs[s].ey)) || (ohp !== 2'(segs[s].ehp)) ||
                (oalive !== 1'(segs[s].ealive)) || (odir !== 2'(segs[s].edir))) begin
                errors++;
                $display("FAIL seg%0d end: got x=%0d y=%0d hp=%0d alive=%0b dir=%0d, want x=%0d y=%0d hp=%0d alive=%0d dir=%0d",
                         s, ox, oy, ohp, oalive, odir,
                         segs[s].ex, segs[s].ey, segs[s].ehp, segs[s].ealive, segs[s].edir);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
